gemm_collect: RTL and testbench

Stream collector and argmax unit for the RL layer pipeline. It sits at the receiving end of a GEMM layer's `ovalid`/`out` result stream. It captures one frame of LENGTH fp16 results into a ping-pong buffer and tracks the running maximum and its index. On frame completion it pulses `done`, so the next layer can read the frame by address while the following frame fills the other bank. The final-layer instance supplies the action index (`max_idx`) to the agent.

---
 rtl/gemm_collect.sv | 169 ++++++++++++++++
 tb/tb_gemm_collect.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_collect.sv
// -----------------------------------------------------------------------------
// gemm_collect
//
// Collects one frame of LENGTH result words from a GEMM layer output stream
// into a ping-pong buffer and tracks the running maximum (fp16 sign-magnitude
// ordering) together with its index. When the last word of a frame arrives the
// banks swap, the frame's max/index are published and 'done' pulses once. The
// downstream layer then reads the completed frame by address while the next
// frame fills the other bank.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   ivalid    result strobe, one word per high cycle, no back-pressure
//   in        result word, sampled when ivalid=1
//   clear     synchronous abort of the partial frame (wins over ivalid)
//   rd_addr   read address into the last completed frame
//   rd_data   registered read data (1-cycle latency)
//   done      one-cycle pulse after a frame completes
//   frame_ok  sticky, high once any frame has completed since reset
//   busy      high while a partial frame is held
//   max_val   maximum of the last completed frame
//   max_idx   index of max_val in the last completed frame
// -----------------------------------------------------------------------------
module gemm_collect #(
    parameter  int LENGTH     = 256,
    parameter  int WIDTH      = 16,
    localparam int ADDR_WIDTH = $clog2(LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ivalid,
    input  logic [WIDTH-1:0]      in,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  done,
    output logic                  frame_ok,
    output logic                  busy,
    output logic [WIDTH-1:0]      max_val,
    output logic [ADDR_WIDTH-1:0] max_idx
);

    localparam int                  DEPTH = 2 ** (ADDR_WIDTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LENGTH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FILL  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   wcnt;
    logic [ADDR_WIDTH-1:0]   wcnt_next;
    logic                    wbank;
    logic                    finish;

    logic [WIDTH-1:0]        run_max;
    logic [ADDR_WIDTH-1:0]   run_idx;

    logic                    accept;
    logic                    take;
    logic [WIDTH-1:0]        cand_val;
    logic [ADDR_WIDTH-1:0]   cand_idx;

    logic [WIDTH-1:0]        mem [DEPTH];

    // Map a sign-magnitude word onto an unsigned key whose natural order
    // matches the fp16 value order. Both zeros map to the same key; negative
    // values invert their magnitude so a smaller magnitude sorts higher.
    function automatic logic [WIDTH-1:0] order_key(input logic [WIDTH-1:0] v);
        logic [WIDTH-2:0] mag;
        mag = v[WIDTH-2:0];
        if (!v[WIDTH-1] || (mag == '0)) begin
            return {1'b1, mag};
        end else begin
            return {1'b0, ~mag};
        end
    endfunction

    function automatic logic greater(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
        return order_key(a) > order_key(b);
    endfunction

    assign accept = ivalid && !clear;

    // Sample 0 of a frame seeds the running max unconditionally; later samples
    // replace it only on a strict win, so ties keep the lowest index.
    assign take     = (state == EMPTY) || greater(in, run_max);
    assign cand_val = take ? in   : run_max;
    assign cand_idx = take ? wcnt : run_idx;

    assign busy = (state == FILL);

    // Next-state / write-counter logic
    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        finish     = 1'b0;
        if (clear) begin
            state_next = EMPTY;
            wcnt_next  = '0;
        end else if (ivalid) begin
            if (wcnt == LAST) begin
                state_next = EMPTY;
                wcnt_next  = '0;
                finish     = 1'b1;
            end else begin
                state_next = FILL;
                wcnt_next  = wcnt + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            wcnt  <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    // Frame completion: swap banks and publish the result including the
    // final sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbank    <= 1'b0;
            done     <= 1'b0;
            frame_ok <= 1'b0;
            max_val  <= '0;
            max_idx  <= '0;
            run_max  <= '0;
            run_idx  <= '0;
        end else begin
            done <= finish;
            if (accept) begin
                run_max <= cand_val;
                run_idx <= cand_idx;
            end
            if (finish) begin
                wbank    <= ~wbank;
                frame_ok <= 1'b1;
                max_val  <= cand_val;
                max_idx  <= cand_idx;
            end
        end
    end

    // Buffer storage; the bank select is the MSB of the address.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[{wbank, wcnt}] <= in;
        end
    end

    // The read side always targets the bank not being filled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[{~wbank, rd_addr}];
        end
    end

endmodule

// File: tb/tb_gemm_collect.sv
module tb_gemm_collect;

    localparam int LENGTH = 256;
    localparam int WIDTH  = 16;
    localparam int AW     = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ivalid;
    logic [15:0]   din;
    logic          clear;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data;
    logic          done;
    logic          frame_ok;
    logic          busy;
    logic [15:0]   max_val;
    logic [AW-1:0] max_idx;

    gemm_collect #(.LENGTH(LENGTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .ivalid   (ivalid),
        .in       (din),
        .clear    (clear),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .done     (done),
        .frame_ok (frame_ok),
        .busy     (busy),
        .max_val  (max_val),
        .max_idx  (max_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int done_q[$];
    always @(negedge clk) if (done === 1'b1) done_q.push_back(cyc);

    int total = 0;
    int bad   = 0;
    logic [15:0] ref_mem [256];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Integer 0..255 to fp16 bit pattern.
    function automatic logic [15:0] fp16_of(input int k);
        int e;
        int m;
        if (k == 0) return 16'h0000;
        e = 0;
        for (int i = 0; i < 8; i++) if ((k >> i) != 0) e = i;
        m = (k << (10 - e)) & 'h3FF;
        return {1'b0, 5'(e + 15), 10'(m)};
    endfunction

    task automatic step(input logic v, input logic [15:0] d);
        ivalid = v;
        din    = d;
        @(posedge clk);
        #1;
        ivalid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; clear = 1'b0; ivalid = 1'b0; din = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rd_data !== 16'h0) begin bad++; $display("FAIL reset rd_data: got %h want 0000", rd_data); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
        total++; if (frame_ok !== 1'b0) begin bad++; $display("FAIL reset frame_ok: got %b want 0", frame_ok); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        total++; if (max_val !== 16'h0) begin bad++; $display("FAIL reset max_val: got %h want 0000", max_val); end
        total++; if (max_idx !== 8'h0) begin bad++; $display("FAIL reset max_idx: got %0d want 0", max_idx); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame;
        done_q.delete();
        for (int k = 0; k < 256; k++) begin
            ref_mem[k] = fp16_of(k);
            step(1'b1, ref_mem[k]);
            if (k == 0) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL single busy_first: got %b want 1", busy); end
            end
            if (k == 254) begin
                total++; if (done !== 1'b0) begin bad++; $display("FAIL single done_early: got %b want 0", done); end
            end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL single done: got %b want 1", done); end
        total++; if (max_idx !== 8'd255) begin bad++; $display("FAIL single max_idx: got %0d want 255", max_idx); end
        total++; if (max_val !== 16'h5BF8) begin bad++; $display("FAIL single max_val: got %h want 5bf8", max_val); end
        total++; if (frame_ok !== 1'b1) begin bad++; $display("FAIL single frame_ok: got %b want 1", frame_ok); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single busy_end: got %b want 0", busy); end
        step(1'b0, 16'h0);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL single done_fall: got %b want 0", done); end
        total++; if (done_q.size() != 1) begin bad++; $display("FAIL single done_count: got %0d want 1", done_q.size()); end
        for (int a = 0; a < 256; a++) begin
            rd_addr = AW'(a);
            @(posedge clk); #1;
            total++; if (rd_data !== ref_mem[a]) begin bad++; $display("FAIL single readback[%0d]: got %h want %h", a, rd_data, ref_mem[a]); end
        end
    endtask

    task automatic test_ties_signs;
        logic [15:0] d;
        for (int k = 0; k < 256; k++) begin
            d = (k % 2 == 0) ? 16'h8000 : 16'h0000;
            if (k == 5) d = 16'hBC00;
            if (k == 10 || k == 200) d = 16'h3C00;
            step(1'b1, d);
        end
        total++; if (max_idx !== 8'd10) begin bad++; $display("FAIL ties max_idx: got %0d want 10", max_idx); end
        total++; if (max_val !== 16'h3C00) begin bad++; $display("FAIL ties max_val: got %h want 3c00", max_val); end
        for (int k = 0; k < 256; k++) begin
            d = (k == 7) ? 16'hB800 : 16'hC000;
            step(1'b1, d);
        end
        total++; if (max_idx !== 8'd7) begin bad++; $display("FAIL negs max_idx: got %0d want 7", max_idx); end
        total++; if (max_val !== 16'hB800) begin bad++; $display("FAIL negs max_val: got %h want b800", max_val); end
        rd_addr = 8'd7;
        @(posedge clk); #1;
        total++; if (rd_data !== 16'hB800) begin bad++; $display("FAIL negs read7: got %h want b800", rd_data); end
        rd_addr = 8'd0;
        @(posedge clk); #1;
        total++; if (rd_data !== 16'hC000) begin bad++; $display("FAIL negs read0: got %h want c000", rd_data); end
    endtask

    task automatic test_back_to_back;
        int start;
        logic [7:0] hi;
        done_q.delete();
        start = cyc;
        for (int f = 0; f < 3; f++) begin
            hi = (f == 0) ? 8'hC1 : (f == 1) ? 8'h52 : 8'h33;
            for (int k = 0; k < 256; k++) begin
                if (f == 1) rd_addr = AW'(k);
                step(1'b1, {hi, 8'(k)});
                if (f == 1) begin
                    total++; if (rd_data !== {8'hC1, 8'(k)}) begin bad++; $display("FAIL b2b frame1_read[%0d]: got %h want %h", k, rd_data, {8'hC1, 8'(k)}); end
                end
            end
            total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b done_f%0d: got %b want 1", f, done); end
            if (f == 0) begin
                total++; if (max_val !== 16'hC100) begin bad++; $display("FAIL b2b max_val_f0: got %h want c100", max_val); end
                total++; if (max_idx !== 8'd0) begin bad++; $display("FAIL b2b max_idx_f0: got %0d want 0", max_idx); end
            end else begin
                total++; if (max_val !== {hi, 8'hFF}) begin bad++; $display("FAIL b2b max_val_f%0d: got %h want %h", f, max_val, {hi, 8'hFF}); end
                total++; if (max_idx !== 8'd255) begin bad++; $display("FAIL b2b max_idx_f%0d: got %0d want 255", f, max_idx); end
            end
        end
        step(1'b0, 16'h0);
        total++; if (done_q.size() != 3) begin bad++; $display("FAIL b2b done_count: got %0d want 3", done_q.size()); end
        for (int i = 0; i < 3 && i < done_q.size(); i++) begin
            total++; if (done_q[i] - start != 256 * (i + 1)) begin bad++; $display("FAIL b2b done_time[%0d]: got %0d want %0d", i, done_q[i] - start, 256 * (i + 1)); end
        end
        for (int a = 0; a < 256; a += 85) begin
            rd_addr = AW'(a);
            @(posedge clk); #1;
            total++; if (rd_data !== {8'h33, 8'(a)}) begin bad++; $display("FAIL b2b frame3_read[%0d]: got %h want %h", a, rd_data, {8'h33, 8'(a)}); end
        end
    endtask

    task automatic test_clear;
        done_q.delete();
        for (int k = 0; k < 100; k++) step(1'b1, 16'h7000);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL clear busy_before: got %b want 1", busy); end
        clear = 1'b1;
        step(1'b1, 16'h7BFF);
        clear = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear busy_after: got %b want 0", busy); end
        total++; if (max_val !== 16'h33FF) begin bad++; $display("FAIL clear max_kept: got %h want 33ff", max_val); end
        total++; if (frame_ok !== 1'b1) begin bad++; $display("FAIL clear frame_ok: got %b want 1", frame_ok); end
        for (int k = 0; k < 256; k++) begin
            step(1'b1, fp16_of(k));
            if (k == 254) begin
                total++; if (done_q.size() != 0 || done !== 1'b0) begin bad++; $display("FAIL clear early_done: got count %0d done %b want 0 0", done_q.size(), done); end
            end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL clear done: got %b want 1", done); end
        total++; if (max_val !== 16'h5BF8) begin bad++; $display("FAIL clear max_val: got %h want 5bf8", max_val); end
        total++; if (max_idx !== 8'd255) begin bad++; $display("FAIL clear max_idx: got %0d want 255", max_idx); end
        for (int a = 0; a < 256; a += 51) begin
            rd_addr = AW'(a);
            @(posedge clk); #1;
            total++; if (rd_data !== fp16_of(a)) begin bad++; $display("FAIL clear read[%0d]: got %h want %h", a, rd_data, fp16_of(a)); end
        end
    endtask

    task automatic test_async_reset;
        done_q.delete();
        for (int k = 0; k < 150; k++) step(1'b1, fp16_of(k));
        #2;
        rst = 1'b1;
        #1;
        total++; if (rd_data !== 16'h0) begin bad++; $display("FAIL arst rd_data: got %h want 0000", rd_data); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL arst done: got %b want 0", done); end
        total++; if (frame_ok !== 1'b0) begin bad++; $display("FAIL arst frame_ok: got %b want 0", frame_ok); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst busy: got %b want 0", busy); end
        total++; if (max_val !== 16'h0) begin bad++; $display("FAIL arst max_val: got %h want 0000", max_val); end
        total++; if (max_idx !== 8'h0) begin bad++; $display("FAIL arst max_idx: got %0d want 0", max_idx); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (done_q.size() != 0) begin bad++; $display("FAIL arst spurious_done: got %0d want 0", done_q.size()); end
        for (int k = 0; k < 256; k++) begin
            ref_mem[k] = fp16_of(255 - k);
            step(1'b1, ref_mem[k]);
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL arst done_after: got %b want 1", done); end
        total++; if (max_idx !== 8'd0) begin bad++; $display("FAIL arst max_idx_after: got %0d want 0", max_idx); end
        total++; if (max_val !== 16'h5BF8) begin bad++; $display("FAIL arst max_val_after: got %h want 5bf8", max_val); end
        for (int a = 0; a < 256; a++) begin
            rd_addr = AW'(a);
            @(posedge clk); #1;
            total++; if (rd_data !== ref_mem[a]) begin bad++; $display("FAIL arst readback[%0d]: got %h want %h", a, rd_data, ref_mem[a]); end
        end
    endtask

    task automatic test_gapped;
        int acc;
        int n;
        logic v;
        logic exp_busy;
        logic exp_done;
        done_q.delete();
        for (int k = 0; k < 256; k++) ref_mem[k] = 16'(k);
        ref_mem[77] = 16'h6000;
        acc = 0;
        n   = 0;
        while (acc < 256 && n < 5000) begin
            v = ($urandom_range(0, 99) < 30);
            step(v, v ? ref_mem[acc] : 16'h0);
            if (v) acc++;
            n++;
            exp_busy = (acc > 0) && (acc < 256);
            exp_done = v && (acc == 256);
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL gap busy@%0d: got %b want %b", n, busy, exp_busy); end
            total++; if (done !== exp_done) begin bad++; $display("FAIL gap done@%0d: got %b want %b", n, done, exp_done); end
        end
        total++; if (acc != 256) begin bad++; $display("FAIL gap timeout: got %0d accepted want 256", acc); end
        step(1'b0, 16'h0);
        total++; if (done_q.size() != 1) begin bad++; $display("FAIL gap done_count: got %0d want 1", done_q.size()); end
        total++; if (max_idx !== 8'd77) begin bad++; $display("FAIL gap max_idx: got %0d want 77", max_idx); end
        total++; if (max_val !== 16'h6000) begin bad++; $display("FAIL gap max_val: got %h want 6000", max_val); end
        rd_addr = 8'd200;
        @(posedge clk); #1;
        total++; if (rd_data !== 16'h00C8) begin bad++; $display("FAIL gap read200: got %h want 00c8", rd_data); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_ties_signs();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_gapped();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
